// File: rtl/serial_rx_buffer.sv
// Receive-side byte FIFO between the serial receiver and the peripheral read path.
// First-word-fall-through output, sticky overrun on drops, and hysteretic RTS flow control.
module serial_rx_buffer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int HIGH_WATER = 12,
    parameter int LOW_WATER  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            in_data,
    input  logic                  in_attention,
    input  logic                  rd,
    output logic [7:0]            rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overrun,
    input  logic                  clr_overrun,
    output logic                  rts_n
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] HW_CNT   = (DEPTH_LOG2 + 1)'(HIGH_WATER);
    localparam logic [DEPTH_LOG2:0] LW_CNT   = (DEPTH_LOG2 + 1)'(LOW_WATER);

    if (!(HIGH_WATER > LOW_WATER && HIGH_WATER <= DEPTH)) begin : g_bad_cfg
        $error("serial_rx_buffer: need LOW_WATER < HIGH_WATER <= 2**DEPTH_LOG2");
    end

    typedef enum logic {ST_RUN = 1'b0, ST_STOP = 1'b1} rts_state_t;

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overrun;
    rts_state_t            r_state;
    logic                  r_rts_n;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [DEPTH_LOG2:0]   w_count_next;

    assign empty   = (r_count == '0);
    assign full    = (r_count == FULL_CNT);
    assign count   = r_count;
    assign overrun = r_overrun;
    assign rts_n   = r_rts_n;
    assign rd_data = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_pop  = rd && !empty;
    assign w_push = in_attention && (!full || w_pop);
    assign w_drop = in_attention && !w_push;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n && w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            // A drop in the same cycle as a clear leaves the flag set.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Thresholds are judged on the next occupancy so RTS moves in the same cycle as count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
            r_rts_n <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_count_next >= HW_CNT) begin
                        r_state <= ST_STOP;
                        r_rts_n <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_count_next <= LW_CNT) begin
                        r_state <= ST_RUN;
                        r_rts_n <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_rts_n <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_rx_buffer.sv
// Bench for serial_rx_buffer: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the FIFO, overrun flag and RTS hysteresis.
module tb_serial_rx_buffer;
    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;
    localparam int HW    = 12;
    localparam int LW    = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [7:0]   in_data;
    logic         in_attention;
    logic         rd;
    logic [7:0]   rd_data;
    logic [DL2:0] count;
    logic         empty;
    logic         full;
    logic         overrun;
    logic         clr_overrun;
    logic         rts_n;

    serial_rx_buffer #(.DEPTH_LOG2(DL2), .HIGH_WATER(HW), .LOW_WATER(LW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_data     (in_data),
        .in_attention(in_attention),
        .rd          (rd),
        .rd_data     (rd_data),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .rts_n       (rts_n)
    );

    always #5 clk = ~clk;

    int       checks = 0;
    int       errors = 0;
    logic [7:0] q[$];
    logic     m_ovr = 1'b0;
    logic     m_rts = 1'b0;
    logic [7:0] last_pop = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), q.size());
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("rts_n", 32'(rts_n), 32'(m_rts));
        if (q.size() != 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
    endtask

    // One clock of traffic; the model applies the same cycle's rules to its own queue.
    task automatic step(input logic att, input logic [7:0] d, input logic r, input logic clr);
        bit do_pop;
        bit do_push;
        in_attention = att;
        in_data      = d;
        rd           = r;
        clr_overrun  = clr;
        do_pop  = r && (q.size() != 0);
        do_push = att && ((q.size() < DEPTH) || do_pop);
        @(posedge clk);
        #1;
        if (do_pop) last_pop = q.pop_front();
        if (do_push) q.push_back(d);
        if (att && !do_push) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        if (q.size() >= HW) m_rts = 1'b1;
        else if (q.size() <= LW) m_rts = 1'b0;
        in_attention = 1'b0;
        rd           = 1'b0;
        clr_overrun  = 1'b0;
        $display("step att=%0d d=%02h rd=%0d clr=%0d -> count=%0d rd_data=%02h ovr=%0d rts_n=%0d",
                 att, d, r, clr, count, rd_data, overrun, rts_n);
        check_all();
    endtask

    // Reset with live-looking inputs, which must be ignored.
    task automatic do_reset();
        reset_n      = 1'b0;
        in_attention = 1'b1;
        in_data      = 8'($urandom);
        rd           = 1'b1;
        clr_overrun  = 1'b0;
        @(posedge clk);
        #1;
        reset_n      = 1'b1;
        in_attention = 1'b0;
        rd           = 1'b0;
        q.delete();
        m_ovr = 1'b0;
        m_rts = 1'b0;
        $display("reset -> count=%0d empty=%0d ovr=%0d rts_n=%0d", count, empty, overrun, rts_n);
        check_all();
    endtask

    initial begin
        reset_n = 1'b0; in_data = 8'h00; in_attention = 1'b0; rd = 1'b0; clr_overrun = 1'b0;
        @(posedge clk);
        do_reset();

        // Three pushes, then three pops.
        step(1, 8'h41, 0, 0); step(1, 8'h42, 0, 0); step(1, 8'h43, 0, 0);
        chk("three_count", 32'(count), 3);
        chk("three_head", 32'(rd_data), 32'h41);
        step(0, 8'h00, 1, 0); chk("pop1_head", 32'(rd_data), 32'h42);
        step(0, 8'h00, 1, 0); chk("pop2_head", 32'(rd_data), 32'h43);
        step(0, 8'h00, 1, 0); chk("pop3_empty", 32'(empty), 1);

        // Fill, drop 0xAA, drop again while clearing (set wins), drain, clear.
        for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0);
        step(1, 8'hAA, 0, 0);
        chk("ovf_full", 32'(full), 1);
        chk("ovf_flag", 32'(overrun), 1);
        step(1, 8'hAB, 0, 1);
        chk("ovf_set_wins", 32'(overrun), 1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", 32'(rd_data), 32'(i));
            step(0, 8'h00, 1, 0);
        end
        step(0, 8'h00, 0, 1);
        chk("ovf_cleared", 32'(overrun), 0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h10 + i), 0, 0);
        step(1, 8'h55, 1, 0);
        chk("fullrw_count", 32'(count), DEPTH);
        chk("fullrw_ovr", 32'(overrun), 0);
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0);
        chk("fullrw_last", 32'(last_pop), 32'h55);

        // Empty with simultaneous push and pop, then RTS hysteresis.
        step(1, 8'h01, 1, 0);
        chk("emptyrw_count", 32'(count), 1);
        for (int i = 1; i < HW; i++) step(1, 8'($urandom), 0, 0);
        chk("hw_rts", 32'(rts_n), 1);
        for (int i = HW; i > 5; i--) step(0, 8'h00, 1, 0);
        chk("hyst_rts", 32'(rts_n), 1);
        step(0, 8'h00, 1, 0);
        chk("lw_rts", 32'(rts_n), 0);
        while (q.size() != 0) step(0, 8'h00, 1, 0);

        // Low-occupancy traffic across pointer wrap, with reads on empty.
        begin
            int pushed = 0;
            int guard  = 0;
            while (pushed < 40 && guard < 2000) begin
                logic a;
                a = (q.size() < 3) ? 1'($urandom) : 1'b0;
                if (a && (q.size() < DEPTH)) pushed++;
                step(a, 8'($urandom), 1'($urandom), 0);
                guard++;
            end
            chk("wrap_budget", 32'(guard < 2000), 1);
            step(0, 8'h00, 1, 0); step(0, 8'h00, 1, 0); step(0, 8'h00, 1, 0);
            step(0, 8'h00, 1, 0);
            chk("no_underflow", 32'(count), 0);
        end

        // Seven bytes with overrun set, then reset; 0x99 must be first out.
        for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h60 + i), 0, 0);
        step(1, 8'hEE, 0, 0);
        for (int i = 0; i < DEPTH - 7; i++) step(0, 8'h00, 1, 0);
        chk("pre_reset_count", 32'(count), 7);
        do_reset();
        chk("post_reset_ovr", 32'(overrun), 0);
        step(1, 8'h99, 0, 0);
        chk("post_reset_head", 32'(rd_data), 32'h99);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) < 6), 8'($urandom), 1'($urandom_range(0, 9) < 4),
                 1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 9) < 3), 8'($urandom), 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_rx_buffer.md
SERIAL_RX_BUFFER -- requirements
Module: serial_rx_buffer

Interface
REQ-001 Parameter DEPTH_LOG2, default 4: FIFO depth = 2**DEPTH_LOG2 bytes.
REQ-002 Parameter HIGH_WATER, default 12: occupancy at or above which flow control throttles the sender.
REQ-003 Parameter LOW_WATER, default 4: occupancy at or below which flow control releases the sender.
REQ-004 clk  input  1  rising-edge system clock, same domain as the serial receiver and the peripheral block.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 in_data  input  8  received byte from the serial receiver.
REQ-007 in_attention  input  1  one-cycle strobe; in_data valid in that cycle.
REQ-008 rd  input  1  pop request from the peripheral read path.
REQ-009 rd_data  output  8  head-of-FIFO byte (first-word-fall-through).
REQ-010 count  output  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2.
REQ-011 empty  output  1  count == 0.
REQ-012 full  output  1  count == 2**DEPTH_LOG2.
REQ-013 overrun  output  1  sticky flag: at least one byte dropped.
REQ-014 clr_overrun  input  1  one-cycle strobe clearing overrun.
REQ-015 rts_n  output  1  active-low request-to-send to the remote sender (0 = may send).

Function
REQ-016 Storage: circular buffer, write pointer and read pointer DEPTH_LOG2 bits each; both wrap modulo 2**DEPTH_LOG2 with no special handling.
REQ-017 Push = in_attention && (!full || pop); on push, in_data is written at the write pointer and the pointer increments.
REQ-018 Pop = rd && !empty; on pop, the read pointer increments; rd while empty is ignored, with no state change.
REQ-019 rd_data SHALL equal the entry at the read pointer combinationally; value is don't-care while empty.
REQ-020 A byte pushed in cycle N SHALL appear on rd_data and make empty deassert in cycle N+1.
REQ-021 count is registered: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-022 Full with simultaneous in_attention and rd: pop and push both occur, count stays at full, no overrun.
REQ-023 Empty with simultaneous in_attention and rd: push only, count becomes 1.
REQ-024 in_attention while full and no pop: byte discarded, FIFO contents unchanged, overrun set the next cycle.
REQ-025 overrun clears on clr_overrun; if clr_overrun and a drop coincide, set wins.
REQ-026 rts_n is a registered two-state machine:
  - RUN (rts_n=0) -> STOP (rts_n=1) when the next count >= HIGH_WATER.
  - STOP -> RUN when the next count <= LOW_WATER.
  - Otherwise hold (hysteresis).
REQ-027 HIGH_WATER SHALL be > LOW_WATER and <= 2**DEPTH_LOG2; violation is a configuration error (elaboration-time check in simulation).
REQ-028 Throughput: one push and one pop per cycle sustained; no bubbles.

Reset
REQ-029 On clk rising edge with reset_n=0, the following SHALL take effect at that edge:
  - both pointers = 0, count = 0, empty = 1, full = 0, overrun = 0, rts_n = 0 (RUN).
REQ-030 Reset mid-operation SHALL discard all stored bytes; FIFO memory contents need not be cleared.
REQ-031 in_attention, rd and clr_overrun are ignored while reset_n=0.

Verification
REQ-032 Reset, then push 0x41, 0x42, 0x43 on consecutive cycles -> count=3, rd_data=0x41; pop three times -> rd_data 0x42, then 0x43, then empty=1, count=0.
REQ-033 Push 16 bytes 0x00..0x0F, then push 0xAA -> full=1, overrun=1, count=16; pop all -> sequence 0x00..0x0F, 0xAA absent; pulse clr_overrun -> overrun=0.
REQ-034 Fill to 16, then in_attention=1 with in_data=0x55 and rd=1 in the same cycle -> count=16, overrun=0, last popped entry is 0x55.
REQ-035 Push until count=12 -> rts_n=1 registered in the same cycle count becomes 12; pop to count=5 -> rts_n remains 1; pop to count=4 -> rts_n=0.
REQ-036 Push/pop 40 bytes with occupancy oscillating 0..3 -> pointer wrap-around is transparent and output order is preserved; rd on empty produces no count underflow.
REQ-037 Load 7 bytes, set overrun, then assert reset_n=0 for one cycle -> count=0, empty=1, overrun=0, rts_n=0; the next pushed byte 0x99 appears first on rd_data.
